// File: rtl/sb_pkg.sv
// ---------------------------------------------------------------------------
// sb_pkg
// Shared constants and types for the receive-side sideband deserializer.
//   SB_DATA_W      : packet width in bits (serial UIs per packet)
//   SB_MIN_GAP     : minimum idle cycles (rx_clk_en low) between packets
//   sb_rx_state_e  : receive FSM state encoding
// ---------------------------------------------------------------------------
package sb_pkg;

    localparam int SB_DATA_W  = 64;
    localparam int SB_MIN_GAP = 32;

    typedef enum logic [1:0] {
        GAP      = 2'd0,
        SHIFT    = 2'd1,
        ERR_WAIT = 2'd2
    } sb_rx_state_e;

endpackage

// File: rtl/sb_deserializer_if.sv
// ---------------------------------------------------------------------------
// sb_deserializer_if
// Bundles the serial input, the packet handshake and the status pulses of
// the sideband deserializer.
//   RXDATASB            : serial sideband bit, LSB first
//   rx_clk_en           : one valid bit per cycle while high
//   de_ser_done_sampled : consumer ack (level)
//   deser_data          : assembled packet, stable while de_ser_done is high
//   de_ser_done         : packet-available level
//   frame_err/gap_err/ovf_err : one-cycle error pulses
//   busy                : deserializer is mid-packet
//   rx_state            : current receive FSM state (debug observation)
// Handshake (four-phase): de_ser_done rises with a packet; the consumer
// raises ack; de_ser_done falls; the consumer drops ack; only then may the
// next packet be loaded.
// Modports: master = deserializer side, slave = line/consumer side.
// ---------------------------------------------------------------------------
interface sb_deserializer_if
    import sb_pkg::*;
#(
    parameter int DATA_W = SB_DATA_W
);
    logic              RXDATASB;
    logic              rx_clk_en;
    logic              de_ser_done_sampled;
    logic [DATA_W-1:0] deser_data;
    logic              de_ser_done;
    logic              frame_err;
    logic              gap_err;
    logic              ovf_err;
    logic              busy;
    sb_rx_state_e      rx_state;

    modport master (
        input  RXDATASB, rx_clk_en, de_ser_done_sampled,
        output deser_data, de_ser_done, frame_err, gap_err, ovf_err, busy,
               rx_state
    );

    modport slave (
        output RXDATASB, rx_clk_en, de_ser_done_sampled,
        input  deser_data, de_ser_done, frame_err, gap_err, ovf_err, busy,
               rx_state
    );
endinterface

// File: rtl/sb_sync2.sv
// ---------------------------------------------------------------------------
// sb_sync2
// Two-flop level synchronizer with synchronous active-high reset (reset 0).
//   clk : destination clock
//   rst : synchronous active-high reset
//   d   : asynchronous level input
//   q   : synchronized level output (2 cycles of latency)
// ---------------------------------------------------------------------------
module sb_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/sb_deserializer.sv
// ---------------------------------------------------------------------------
// sb_deserializer
// Receive-side sideband deserializer. Shifts in one bit per cycle while
// rx_clk_en is high, assembles DATA_W-bit packets (LSB first), enforces a
// MIN_GAP idle gap between packets and hands each packet to the consumer
// through a one-entry holding register and a four-phase handshake.
// Ports:
//   clk : sideband UI-rate clock
//   rst : synchronous active-high reset
//   sb  : sb_deserializer_if.master (serial in, handshake, status out)
// Build option:
//   SB_ACK_SYNC_EN : when defined, de_ser_done_sampled passes through a
//                    2-flop synchronizer before use (2 extra cycles of ack
//                    latency); otherwise it is used directly.
// ---------------------------------------------------------------------------
module sb_deserializer
    import sb_pkg::*;
#(
    parameter int DATA_W  = SB_DATA_W,
    parameter int MIN_GAP = SB_MIN_GAP,
    parameter int CNT_W   = $clog2(DATA_W) + 1
) (
    input logic               clk,
    input logic               rst,
    sb_deserializer_if.master sb
);
    localparam int               IDX_W     = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] GAP_FULL  = CNT_W'(MIN_GAP);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    sb_rx_state_e      state_q,     state_d;
    logic [CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
    logic [CNT_W-1:0]  gap_cnt_q,   gap_cnt_d;
    logic [DATA_W-1:0] shift_q,     shift_d;
    logic              cmpl_q,      cmpl_d;
    logic [DATA_W-1:0] data_q,      data_d;
    logic              done_q,      done_d;
    logic              frame_err_q, frame_err_d;
    logic              gap_err_q,   gap_err_d;
    logic              ovf_err_q,   ovf_err_d;
    logic              ack_s;

`ifdef SB_ACK_SYNC_EN
    sb_sync2 u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (sb.de_ser_done_sampled),
        .q   (ack_s)
    );
`else
    assign ack_s = sb.de_ser_done_sampled;
`endif

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        shift_d     = shift_q;
        cmpl_d      = 1'b0;
        data_d      = data_q;
        done_d      = done_q;
        frame_err_d = 1'b0;
        gap_err_d   = 1'b0;
        ovf_err_d   = 1'b0;

        unique case (state_q)
            GAP: begin
                if (sb.rx_clk_en) begin
                    if (gap_cnt_q >= GAP_FULL) begin
                        // This cycle's bit is bit 0 of a fresh packet.
                        state_d    = SHIFT;
                        shift_d    = '0;
                        shift_d[0] = sb.RXDATASB;
                        bit_cnt_d  = CNT_ONE;
                    end else begin
                        gap_err_d = 1'b1;
                        state_d   = ERR_WAIT;
                    end
                end else if (gap_cnt_q < GAP_FULL) begin
                    gap_cnt_d = gap_cnt_q + CNT_ONE;
                end
            end
            SHIFT: begin
                if (sb.rx_clk_en) begin
                    shift_d[bit_cnt_q[IDX_W-1:0]] = sb.RXDATASB;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d   = GAP;
                        gap_cnt_d = '0;
                        bit_cnt_d = '0;
                        cmpl_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                    end
                end else begin
                    // Clock activity dropped mid-packet: discard, and this
                    // idle cycle already counts toward the next gap.
                    frame_err_d = 1'b1;
                    state_d     = GAP;
                    gap_cnt_d   = CNT_ONE;
                    bit_cnt_d   = '0;
                    shift_d     = '0;
                end
            end
            ERR_WAIT: begin
                if (!sb.rx_clk_en) begin
                    state_d   = GAP;
                    gap_cnt_d = CNT_ONE;
                end
            end
            default: begin
                state_d = GAP;
            end
        endcase

        // Ack-driven fall of the done level.
        if (done_q && ack_s) begin
            done_d = 1'b0;
        end

        // Offer the completed word one cycle after its last bit. The register
        // is free only when neither done nor ack is high, so a completion
        // coinciding with an ack-driven fall is dropped.
        if (cmpl_q) begin
            if (!done_q && !ack_s) begin
                data_d = shift_q;
                done_d = 1'b1;
            end else begin
                ovf_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= GAP;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= GAP_FULL;
            shift_q     <= '0;
            cmpl_q      <= 1'b0;
            data_q      <= '0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            gap_err_q   <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            shift_q     <= shift_d;
            cmpl_q      <= cmpl_d;
            data_q      <= data_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
            gap_err_q   <= gap_err_d;
            ovf_err_q   <= ovf_err_d;
        end
    end

    assign sb.deser_data  = data_q;
    assign sb.de_ser_done = done_q;
    assign sb.frame_err   = frame_err_q;
    assign sb.gap_err     = gap_err_q;
    assign sb.ovf_err     = ovf_err_q;
    assign sb.busy        = (state_q == SHIFT);
    assign sb.rx_state    = state_q;
endmodule

// File: tb/tb_sb_deserializer.sv
// ---------------------------------------------------------------------------
// tb_sb_deserializer
// Directed self-checking bench for sb_deserializer. Works in both builds;
// ACK_LAT accounts for the optional ack synchronizer.
// ---------------------------------------------------------------------------
module tb_sb_deserializer;
    import sb_pkg::*;

`ifdef SB_ACK_SYNC_EN
    localparam int ACK_LAT = 2;
`else
    localparam int ACK_LAT = 0;
`endif

    localparam logic [63:0] P_A = 64'hA5A5_0000_DEAD_BEEF;
    localparam logic [63:0] P_B = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] P_C = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] P_D = 64'h8000_0000_0000_0001;
    localparam logic [63:0] P_E = 64'hFFFF_0000_FFFF_0000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sb_deserializer_if bus ();

    sb_deserializer dut (
        .clk (clk),
        .rst (rst),
        .sb  (bus)
    );

    int errors = 0;
    int checks = 0;
    int idle_run = 0;

    // Pulse / edge counters sampled mid-cycle.
    int   n_frame = 0;
    int   n_gap   = 0;
    int   n_ovf   = 0;
    int   n_rise  = 0;
    logic done_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.frame_err === 1'b1) n_frame++;
        if (bus.gap_err   === 1'b1) n_gap++;
        if (bus.ovf_err   === 1'b1) n_ovf++;
        if (bus.de_ser_done === 1'b1 && done_prev !== 1'b1) n_rise++;
        done_prev = bus.de_ser_done;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.rx_clk_en) idle_run = 0;
        else               idle_run++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.rx_clk_en = 1'b0;
        bus.RXDATASB = 1'b0;
        bus.de_ser_done_sampled = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send_bits(input logic [63:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            bus.rx_clk_en = 1'b1;
            bus.RXDATASB = d[i];
            tick();
        end
        bus.rx_clk_en = 1'b0;
        bus.RXDATASB = 1'b0;
    endtask

    task automatic pad_gap(input int n);
        bus.rx_clk_en = 1'b0;
        while (idle_run < n) tick();
    endtask

    // Full handshake; k = cycles from ack rise until done observed low.
    task automatic ack_handshake(output int k);
        bus.de_ser_done_sampled = 1'b1;
        k = 0;
        do begin
            tick();
            k++;
        end while (bus.de_ser_done !== 1'b0 && k < 10);
        bus.de_ser_done_sampled = 1'b0;
        repeat (ACK_LAT + 1) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (bus.deser_data !== 64'h0) begin errors++; $display("FAIL reset_data: got %h expected %h", bus.deser_data, 64'h0); end
        checks++; if (bus.de_ser_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.de_ser_done); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", bus.frame_err); end
        checks++; if (bus.gap_err !== 1'b0) begin errors++; $display("FAIL reset_gap_err: got %b expected 0", bus.gap_err); end
        checks++; if (bus.ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf_err: got %b expected 0", bus.ovf_err); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.rx_state !== GAP) begin errors++; $display("FAIL reset_state: got %0d expected %0d", bus.rx_state, GAP); end
    endtask

    task automatic test_basic();
        int k;
        int e0;
        do_reset();
        e0 = n_frame + n_gap + n_ovf;
        send_bits(P_A, 64);
        checks++; if (bus.de_ser_done !== 1'b0) begin errors++; $display("FAIL basic_done_early: got %b expected 0", bus.de_ser_done); end
        tick();
        checks++; if (bus.de_ser_done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b expected 1", bus.de_ser_done); end
        checks++; if (bus.deser_data !== P_A) begin errors++; $display("FAIL basic_data: got %h expected %h", bus.deser_data, P_A); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b expected 0", bus.busy); end
        ack_handshake(k);
        checks++; if (k != 1 + ACK_LAT) begin errors++; $display("FAIL basic_ack_latency: got %0d expected %0d", k, 1 + ACK_LAT); end
        checks++; if (n_frame + n_gap + n_ovf != e0) begin errors++; $display("FAIL basic_no_err: got %0d expected %0d", n_frame + n_gap + n_ovf, e0); end
    endtask

    task automatic test_back_to_back();
        int k;
        int e0;
        int r0;
        int g0;
        do_reset();
        e0 = n_frame + n_gap + n_ovf;
        r0 = n_rise;
        send_bits(P_B, 64);
        tick();
        checks++; if (bus.deser_data !== P_B) begin errors++; $display("FAIL b2b_data1: got %h expected %h", bus.deser_data, P_B); end
        ack_handshake(k);
        pad_gap(32);
        send_bits(P_C, 64);
        tick();
        checks++; if (bus.de_ser_done !== 1'b1) begin errors++; $display("FAIL b2b_done2: got %b expected 1", bus.de_ser_done); end
        checks++; if (bus.deser_data !== P_C) begin errors++; $display("FAIL b2b_data2: got %h expected %h", bus.deser_data, P_C); end
        ack_handshake(k);
        checks++; if (n_frame + n_gap + n_ovf != e0) begin errors++; $display("FAIL b2b_no_err: got %0d expected %0d", n_frame + n_gap + n_ovf, e0); end
        checks++; if (n_rise - r0 != 2) begin errors++; $display("FAIL b2b_deliveries: got %0d expected 2", n_rise - r0); end
        // One idle cycle short of the minimum gap.
        g0 = n_gap;
        pad_gap(31);
        send_bits(P_D, 64);
        repeat (4) tick();
        checks++; if (n_gap - g0 != 1) begin errors++; $display("FAIL short_gap_err: got %0d expected 1", n_gap - g0); end
        checks++; if (bus.de_ser_done !== 1'b0) begin errors++; $display("FAIL short_gap_done: got %b expected 0", bus.de_ser_done); end
        checks++; if (n_rise - r0 != 2) begin errors++; $display("FAIL short_gap_dropped: got %0d expected 2", n_rise - r0); end
    endtask

    task automatic test_frame_err();
        int k;
        int f0;
        int r0;
        do_reset();
        f0 = n_frame;
        r0 = n_rise;
        send_bits(P_E, 40);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL frame_busy: got %b expected 1", bus.busy); end
        tick();
        checks++; if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL frame_pulse: got %b expected 1", bus.frame_err); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL frame_busy_drop: got %b expected 0", bus.busy); end
        tick();
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL frame_pulse_end: got %b expected 0", bus.frame_err); end
        pad_gap(32);
        send_bits(P_A, 64);
        tick();
        checks++; if (bus.deser_data !== P_A) begin errors++; $display("FAIL frame_next_data: got %h expected %h", bus.deser_data, P_A); end
        ack_handshake(k);
        checks++; if (n_frame - f0 != 1) begin errors++; $display("FAIL frame_count: got %0d expected 1", n_frame - f0); end
        checks++; if (n_rise - r0 != 1) begin errors++; $display("FAIL frame_deliveries: got %0d expected 1", n_rise - r0); end
    endtask

    task automatic test_overflow();
        int k;
        int o0;
        do_reset();
        o0 = n_ovf;
        send_bits(P_B, 64);
        tick();
        pad_gap(32);
        send_bits(P_C, 64);
        tick();
        checks++; if (bus.ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b expected 1", bus.ovf_err); end
        checks++; if (bus.deser_data !== P_B) begin errors++; $display("FAIL ovf_data_held: got %h expected %h", bus.deser_data, P_B); end
        checks++; if (bus.de_ser_done !== 1'b1) begin errors++; $display("FAIL ovf_done_held: got %b expected 1", bus.de_ser_done); end
        tick();
        checks++; if (bus.ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_pulse_end: got %b expected 0", bus.ovf_err); end
        ack_handshake(k);
        checks++; if (n_ovf - o0 != 1) begin errors++; $display("FAIL ovf_count: got %0d expected 1", n_ovf - o0); end
    endtask

    task automatic test_reset_mid();
        int k;
        int r0;
        int f0;
        do_reset();
        f0 = n_frame;
        send_bits(P_D, 64);
        tick();
        pad_gap(32);
        send_bits(P_E, 20);
        rst = 1'b1;
        tick();
        checks++; if (bus.deser_data !== 64'h0) begin errors++; $display("FAIL rstmid_data: got %h expected %h", bus.deser_data, 64'h0); end
        checks++; if (bus.de_ser_done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", bus.de_ser_done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
        tick();
        rst = 1'b0;
        r0 = n_rise;
        send_bits(P_C, 64);
        tick();
        checks++; if (bus.deser_data !== P_C) begin errors++; $display("FAIL rstmid_fresh_data: got %h expected %h", bus.deser_data, P_C); end
        ack_handshake(k);
        checks++; if (n_rise - r0 != 1) begin errors++; $display("FAIL rstmid_deliveries: got %0d expected 1", n_rise - r0); end
        checks++; if (n_frame != f0) begin errors++; $display("FAIL rstmid_frame: got %0d expected %0d", n_frame, f0); end
    endtask

    task automatic test_ack_held();
        int k;
        int o0;
        do_reset();
        o0 = n_ovf;
        send_bits(P_A, 64);
        tick();
        checks++; if (bus.deser_data !== P_A) begin errors++; $display("FAIL ackheld_data1: got %h expected %h", bus.deser_data, P_A); end
        bus.de_ser_done_sampled = 1'b1;
        k = 0;
        do begin
            tick();
            k++;
        end while (bus.de_ser_done !== 1'b0 && k < 10);
        checks++; if (k != 1 + ACK_LAT) begin errors++; $display("FAIL ackheld_fall: got %0d expected %0d", k, 1 + ACK_LAT); end
        pad_gap(32);
        send_bits(P_B, 64);
        tick();
        checks++; if (bus.ovf_err !== 1'b1) begin errors++; $display("FAIL ackheld_ovf: got %b expected 1", bus.ovf_err); end
        checks++; if (bus.de_ser_done !== 1'b0) begin errors++; $display("FAIL ackheld_done: got %b expected 0", bus.de_ser_done); end
        checks++; if (bus.deser_data !== P_A) begin errors++; $display("FAIL ackheld_data_held: got %h expected %h", bus.deser_data, P_A); end
        bus.de_ser_done_sampled = 1'b0;
        repeat (ACK_LAT + 1) tick();
        pad_gap(32);
        send_bits(P_D, 64);
        tick();
        checks++; if (bus.de_ser_done !== 1'b1) begin errors++; $display("FAIL ackheld_next_done: got %b expected 1", bus.de_ser_done); end
        checks++; if (bus.deser_data !== P_D) begin errors++; $display("FAIL ackheld_next_data: got %h expected %h", bus.deser_data, P_D); end
        ack_handshake(k);
        checks++; if (n_ovf - o0 != 1) begin errors++; $display("FAIL ackheld_ovf_count: got %0d expected 1", n_ovf - o0); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        bus.rx_clk_en = 1'b0;
        bus.RXDATASB = 1'b0;
        bus.de_ser_done_sampled = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_frame_err();
        test_overflow();
        test_reset_mid();
        test_ack_held();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
